// File: rtl/mem_access_unit.sv
// Data-memory access unit: packs stores into byte lanes, extends loads, and
// sequences one CPU request at a time through a req/ack memory handshake.
module mem_access_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state, state_nxt;
  logic [1:0]       size_q;
  logic             sign_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt;
  logic             bad_req;
  logic             timeout_hit;
  logic             accept;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      load_data;

  always_comb begin
    bad_req = (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
  end

  // Counter holds the number of ack-less ISSUE cycles already spent.
  always_comb begin
    timeout_hit = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT - 1));
  end

  always_comb begin
    accept = (state == IDLE) && req_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = bad_req ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_req = 1'b1;
        if (mem_ack || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_data = {{24{sign_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{sign_q & ld_half[15]}}, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      size_q     <= '0;
      sign_q     <= 1'b0;
      off_q      <= '0;
      cnt        <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      size_q     <= req_size;
      sign_q     <= req_sign;
      off_q      <= req_addr[1:0];
      cnt        <= '0;
      mem_we     <= req_we;
      mem_addr   <= {req_addr[31:2], 2'b00};
      resp_rdata <= '0;
      resp_err   <= bad_req;
      case (req_size)
        2'b00:   mem_wdata <= {4{req_wdata[7:0]}};
        2'b01:   mem_wdata <= {2{req_wdata[15:0]}};
        default: mem_wdata <= req_wdata;
      endcase
      if (!req_we)                mem_be <= 4'b1111;
      else if (req_size == 2'b00) mem_be <= 4'b0001 << req_addr[1:0];
      else if (req_size == 2'b01) mem_be <= req_addr[1] ? 4'b1100 : 4'b0011;
      else                        mem_be <= 4'b1111;
    end else if (state == ISSUE) begin
      // Ack takes priority over a timeout expiring in the same cycle.
      if (mem_ack) begin
        resp_rdata <= mem_we ? '0 : load_data;
        resp_err   <= 1'b0;
      end else if (timeout_hit) begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access unit between the CPU datapath and a word-organised data memory with variable latency.
- On stores, narrows 32-bit register data to byte or halfword lanes and generates byte enables.
- On loads, extracts the addressed byte or halfword from the returned word and zero- or sign-extends it to 32 bits.
- Accepts one request at a time over a valid/ready handshake, issues it to memory over a req/ack handshake, and returns one response per request.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles ISSUE waits for mem_ack before aborting with error; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  CPU request valid
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low byte or halfword used for narrow stores
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or illegal size, or timeout; qualified by resp_valid
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  memory write
- mem_be  output  4  byte enables, little-endian: lane k = bits 8k+7:8k
- mem_addr  output  32  word address, {req_addr[31:2], 2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  memory completion, one cycle; mem_rdata valid in the same cycle
- mem_rdata  input  32  memory read word

Behaviour:
- States: IDLE, ISSUE, RESP. Reset (reset=0) forces IDLE asynchronously.
- All registered outputs reset to 0; req_ready=1 whenever the state is IDLE, including during reset.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we, size, sign, addr and wdata.
  - If misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) or size=11, go to RESP with err=1 and issue no memory access.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req=1, req_ready=0; mem outputs held stable until ack.
  - On mem_ack, latch the processed result and go to RESP.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with no ack, drop mem_req, set err=1 and go to RESP.
  - The counter clears on entry to ISSUE.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in this state.
- Latency:
  - Request accepted at edge T; mem_req is high in cycle T+1.
  - Ack at edge A gives resp_valid in cycle A+1.
  - Zero-wait memory (ack in the first ISSUE cycle) gives a 3-cycle request-to-response time.
- Store packing:
  - Byte: wdata = {4{wdata[7:0]}}, be = 4'b0001 << addr[1:0].
  - Half: wdata = {2{wdata[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: be = 4'b1111.
- Loads: be = 4'b1111, mem_we=0.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend (replicate the lane MSB) if sign=1, else zero-fill.
  - Word passes through; sign is ignored.
- Stores: resp_rdata=0, resp_err=0 on success.
- A new req_valid while not in IDLE is not accepted; the requester holds it until req_ready.
- mem_ack outside ISSUE is ignored.
- An ack in the same cycle the timeout expires counts as success.
- Reset asserted mid-ISSUE: mem_req drops immediately, the transaction is lost, and no response is produced.

Test Plan:
- Load byte, addr=0x13, sign=1, mem_rdata=0x80FF_1234, ack after 2 wait cycles -> mem_addr=0x10, be=1111, resp_rdata=0xFFFFFF80, err=0, resp_valid 1 cycle after ack.
- Same as above with sign=0 -> 0x00000080. Halfword addr=0x12, sign=1, rdata=0x8001_7FFF -> 0xFFFF8001. Halfword addr=0x10 -> 0x00007FFF.
- Store byte addr=0x21, wdata=0xDEADBEEF -> mem_addr=0x20, be=0010, mem_wdata=0xEFEFEFEF, mem_we=1. Store halfword addr=0x22 -> be=1100, mem_wdata=0xBEEFBEEF. Store word -> be=1111.
- Misaligned word addr=0x06, and req_size=11 -> no mem_req ever asserted, resp_valid with err=1, rdata=0, two cycles after acceptance.
- MEM_TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then resp err=1. Next request is accepted normally.
- Reset pulled low during ISSUE -> mem_req low in the same cycle, no resp_valid. After release, req_ready=1 and a word load of 0x12345678 returns 0x12345678.
